// File: rtl/reram_func_core_p.sv
// ReRAM functional core: ROWS x COLS cell array; writes queue the cell address, reads pop it in write order.
// Latency: write ack WR_DLY cycles after acceptance; read ack RD_DLY cycles after acceptance, held RD_HOLD cycles.
// Backpressure: busy blocks new commands; write-when-full / read-when-empty are dropped; EN low aborts a pending read.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock; asynchronous active-low reset
//   EN, R_WB                command strobe (re-armed only after EN is seen low) and direction (1 = read)
//   wbs_dat_i               write command: row [29:25], column [24:20], data [DATA_W-1:0]
//   read_data               last completed read, zero-extended
//   func_ack, busy          completion pulse / FSM not idle
//   fifo_full/empty/count   address FIFO status
//   err_o                   only with RERAM_ERR_ACK_EN defined: flags dropped commands and aborted reads
//
// Optional feature macro: RERAM_ERR_ACK_EN

module reram_func_core_p #(
    parameter int ROWS    = 32,
    parameter int COLS    = 32,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 32,
    parameter int RD_DLY  = 44,
    parameter int WR_DLY  = 0,
    parameter int RD_HOLD = 1
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         EN,
    input  logic                         R_WB,
    input  logic [31:0]                  wbs_dat_i,
    output logic [31:0]                  read_data,
    output logic                         func_ack,
    output logic                         busy,
    output logic                         fifo_full,
    output logic                         fifo_empty,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
`ifdef RERAM_ERR_ACK_EN
    ,
    output logic                         err_o
`endif
);

    localparam int  RW      = $clog2(ROWS);
    localparam int  CW      = $clog2(COLS);
    localparam int  AW      = RW + CW;
    localparam int  FC_W    = $clog2(DEPTH + 1);
    localparam int  MAX_A   = (RD_DLY > WR_DLY) ? RD_DLY : WR_DLY;
    localparam int  MAX_DLY = (MAX_A > RD_HOLD) ? MAX_A : RD_HOLD;
    localparam int  CNT_W   = $clog2(MAX_DLY + 1);
    localparam bit  WR_NOW  = (WR_DLY == 0);

    typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT, RD_ACK} state_t;

    state_t              state;
    logic                armed;
    logic [CNT_W-1:0]    cnt;
    logic [AW-1:0]       wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W-1:0]   cells [ROWS*COLS];

    logic [AW-1:0]       cmd_addr;
    logic [DATA_W-1:0]   cmd_data;
    logic [AW-1:0]       commit_addr;
    logic [DATA_W-1:0]   commit_data;
    logic [AW-1:0]       head_addr;
    logic                accept, wr_go, rd_go, wr_commit, rd_done, cell_we;
    logic                unused_dat;

`ifdef RERAM_ERR_ACK_EN
    logic                drop;
    logic                err_pend;
    assign drop = accept && (R_WB ? fifo_empty : fifo_full);
`endif

    // Upper field bits beyond the array size are intentionally ignored.
    assign cmd_addr   = {wbs_dat_i[25 +: RW], wbs_dat_i[20 +: CW]};
    assign cmd_data   = wbs_dat_i[DATA_W-1:0];
    assign unused_dat = ^wbs_dat_i;

    assign accept    = (state == IDLE) && EN && armed;
    assign wr_go     = accept && !R_WB && !fifo_full;
    assign rd_go     = accept &&  R_WB && !fifo_empty;
    assign rd_done   = (state == RD_WAIT) && EN && (cnt == '0);
    assign wr_commit = WR_NOW ? wr_go : ((state == WR_WAIT) && (cnt == '0));

    // Zero-latency writes commit straight from the bus; delayed writes use the captured copy.
    assign commit_addr = WR_NOW ? cmd_addr : wr_addr;
    assign commit_data = WR_NOW ? cmd_data : wr_data;

    // An edge that lands while reset is held must not corrupt the array.
    assign cell_we = wr_commit && wb_rst_i;

    assign busy       = (state != IDLE);
    assign fifo_full  = (fifo_count == FC_W'(DEPTH));
    assign fifo_empty = (fifo_count == '0);

    always_ff @(posedge wb_clk_i) begin
        if (cell_we) begin
            cells[commit_addr] <= commit_data;
        end
    end

    reram_addr_fifo #(
        .W     (AW),
        .DEPTH (DEPTH)
    ) u_addr_fifo (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_i),
        .push_vld (wr_commit),
        .push_dat (commit_addr),
        .pop_vld  (rd_done),
        .pop_dat  (head_addr),
        .count    (fifo_count)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state     <= IDLE;
            armed     <= 1'b1;
            cnt       <= '0;
            func_ack  <= 1'b0;
            read_data <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
`ifdef RERAM_ERR_ACK_EN
            err_pend  <= 1'b0;
            err_o     <= 1'b0;
`endif
        end else begin
            // A held-high EN can issue only one command.
            if (accept) begin
                armed <= 1'b0;
            end else if (!EN) begin
                armed <= 1'b1;
            end
`ifdef RERAM_ERR_ACK_EN
            err_o    <= 1'b0;
            err_pend <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    func_ack <= 1'b0;
`ifdef RERAM_ERR_ACK_EN
                    // Dropped command from the previous edge reports one cycle later.
                    if (err_pend) begin
                        func_ack <= 1'b1;
                        err_o    <= 1'b1;
                    end
                    if (drop) begin
                        err_pend <= 1'b1;
                    end
`endif
                    if (wr_go) begin
                        if (WR_NOW) begin
                            func_ack <= 1'b1;
                        end else begin
                            state   <= WR_WAIT;
                            cnt     <= CNT_W'(WR_DLY - 1);
                            wr_addr <= cmd_addr;
                            wr_data <= cmd_data;
                        end
                    end else if (rd_go) begin
                        state <= RD_WAIT;
                        cnt   <= CNT_W'(RD_DLY - 1);
                    end
                end
                WR_WAIT: begin
                    if (cnt == '0) begin
                        func_ack <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (!EN) begin
                        state <= IDLE;
`ifdef RERAM_ERR_ACK_EN
                        err_o <= 1'b1;
`endif
                    end else if (cnt == '0) begin
                        func_ack  <= 1'b1;
                        read_data <= 32'(cells[head_addr]);
                        state     <= RD_ACK;
                        cnt       <= CNT_W'(RD_HOLD - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RD_ACK: begin
                    if (cnt == '0) begin
                        func_ack <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// Address FIFO: DEPTH entries of W bits, head presented combinationally.
// Latency: push visible at the head on the next cycle; pop takes effect on the edge.
// Backpressure: none internally; the caller never pushes when full or pops when empty.
module reram_addr_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push_vld,
    input  logic [W-1:0]                push_dat,
    input  logic                        pop_vld,
    output logic [W-1:0]                pop_dat,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_vld) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_vld && !pop_vld) begin
                count <= count + 1'b1;
            end else if (pop_vld && !push_vld) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reram_func_core_p.sv
// Bench for reram_func_core_p: a default-parameter instance and a small instance
// with write latency, long ack hold and narrow address decode, exercised one at a time.
module tb_reram_func_core_p;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        en, r_wb;
    logic [31:0] wbs_dat;
    bit          sel;

    logic        en0, en1;
    logic [31:0] rd0, rd1;
    logic        ack0, ack1, busy0, busy1, full0, full1, empty0, empty1;
    logic [5:0]  cnt0;
    logic [2:0]  cnt1;
`ifdef RERAM_ERR_ACK_EN
    logic        err0, err1, err;
`endif

    logic [31:0] rd, cnt;
    logic        ack, busy, full, empty;

    assign en0 = en & ~sel;
    assign en1 = en &  sel;

    reram_func_core_p dut0 (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .EN         (en0),
        .R_WB       (r_wb),
        .wbs_dat_i  (wbs_dat),
        .read_data  (rd0),
        .func_ack   (ack0),
        .busy       (busy0),
        .fifo_full  (full0),
        .fifo_empty (empty0),
        .fifo_count (cnt0)
`ifdef RERAM_ERR_ACK_EN
        ,
        .err_o      (err0)
`endif
    );

    reram_func_core_p #(
        .ROWS(8), .COLS(4), .DATA_W(12), .DEPTH(4),
        .RD_DLY(5), .WR_DLY(3), .RD_HOLD(4)
    ) dut1 (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .EN         (en1),
        .R_WB       (r_wb),
        .wbs_dat_i  (wbs_dat),
        .read_data  (rd1),
        .func_ack   (ack1),
        .busy       (busy1),
        .fifo_full  (full1),
        .fifo_empty (empty1),
        .fifo_count (cnt1)
`ifdef RERAM_ERR_ACK_EN
        ,
        .err_o      (err1)
`endif
    );

    always_comb begin
        rd    = sel ? rd1 : rd0;
        ack   = sel ? ack1 : ack0;
        busy  = sel ? busy1 : busy0;
        full  = sel ? full1 : full0;
        empty = sel ? empty1 : empty0;
        cnt   = sel ? 32'(cnt1) : 32'(cnt0);
`ifdef RERAM_ERR_ACK_EN
        err   = sel ? err1 : err0;
`endif
    end

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    // Reference model: cell contents by (row*32+col), queue of written-but-unread cells.
    int          tests, fails;
    int          rows, cols, dw, depth, rdl, wdl, hold;
    logic [31:0] mmem [1024];
    int          q [$];
    logic [31:0] exp_rd;

    function automatic int key(input logic [31:0] d);
        return (int'(d[29:25]) % rows) * 32 + (int'(d[24:20]) % cols);
    endfunction

    function automatic logic [31:0] dval(input logic [31:0] d);
        return d & ((32'd1 << dw) - 32'd1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge wb_clk_i);
    endtask

    task automatic do_reset();
        en = 1'b0; r_wb = 1'b0; wbs_dat = '0;
        #2 wb_rst_i = 1'b0;
        #1;
        chk("rst_read_data", rd, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", cnt, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        q.delete();
        exp_rd = '0;
    endtask

    task automatic do_write(input logic [31:0] d);
        bit is_full;
        is_full = (q.size() == depth);
        wbs_dat = d; en = 1'b1; r_wb = 1'b0;
        tick();
        if (is_full) begin
            chk("wrfull_ack", ack, 0);
            chk("wrfull_busy", busy, 0);
            en = 1'b0;
            tick();
`ifdef RERAM_ERR_ACK_EN
            chk("wrfull_err_ack", ack, 1);
            chk("wrfull_err", err, 1);
            tick();
            chk("wrfull_err_clr", err, 0);
`else
            chk("wrfull_ack_late", ack, 0);
`endif
            chk("wrfull_count", cnt, depth);
            chk("wrfull_full", full, 1);
            return;
        end
        if (wdl == 0) begin
            chk("wr_ack", ack, 1);
            chk("wr_busy", busy, 0);
        end else begin
            chk("wr_busy_t", busy, 1);
            chk("wr_ack_t", ack, 0);
            en = 1'b0;
            for (int k = 1; k < wdl; k++) begin
                tick();
                chk("wr_wait_busy", busy, 1);
                chk("wr_wait_ack", ack, 0);
            end
            tick();
            chk("wr_lat_ack", ack, 1);
            chk("wr_lat_busy", busy, 0);
        end
        mmem[key(d)] = dval(d);
        q.push_back(key(d));
        chk("wr_count", cnt, q.size());
        chk("wr_full", full, (q.size() == depth));
        chk("wr_empty", empty, 0);
        en = 1'b0;
        tick();
        chk("wr_ack_clr", ack, 0);
    endtask

    task automatic do_read(input int abort_at);
        bit is_empty;
        is_empty = (q.size() == 0);
        en = 1'b1; r_wb = 1'b1;
        tick();
        if (is_empty) begin
            chk("rdempty_busy", busy, 0);
            chk("rdempty_ack", ack, 0);
            en = 1'b0;
            tick();
`ifdef RERAM_ERR_ACK_EN
            chk("rdempty_err_ack", ack, 1);
            chk("rdempty_err", err, 1);
            tick();
            chk("rdempty_err_clr", ack, 0);
`else
            chk("rdempty_ack_late", ack, 0);
`endif
            chk("rdempty_data", rd, exp_rd);
            return;
        end
        chk("rd_busy_t", busy, 1);
        for (int k = 1; k <= rdl; k++) begin
            if (k == abort_at) en = 1'b0;
            tick();
            if (k == abort_at) begin
                chk("abort_busy", busy, 0);
                chk("abort_ack", ack, 0);
                chk("abort_data", rd, exp_rd);
                chk("abort_count", cnt, q.size());
`ifdef RERAM_ERR_ACK_EN
                chk("abort_err", err, 1);
`endif
                return;
            end
            if (k < rdl) begin
                chk("rd_wait_ack", ack, 0);
                chk("rd_wait_busy", busy, 1);
            end
        end
        exp_rd = mmem[q.pop_front()];
        chk("rd_ack", ack, 1);
        chk("rd_data", rd, exp_rd);
        chk("rd_count", cnt, q.size());
        en = 1'b0;
        for (int h = 2; h <= hold; h++) begin
            tick();
            chk("rd_hold_ack", ack, 1);
            chk("rd_hold_busy", busy, 1);
        end
        tick();
        chk("rd_ack_clr", ack, 0);
        chk("rd_idle", busy, 0);
        chk("rd_data_hold", rd, exp_rd);
    endtask

    // EN stays high for 100 cycles; only one write may result.
    task automatic do_rearm(input logic [31:0] d);
        wbs_dat = d; en = 1'b1; r_wb = 1'b0;
        tick();
        chk("rearm_ack", ack, 1);
        repeat (99) tick();
        mmem[key(d)] = dval(d);
        q.push_back(key(d));
        chk("rearm_count", cnt, q.size());
        chk("rearm_ack_low", ack, 0);
        en = 1'b0;
        tick();
    endtask

    logic [31:0] d, first;

    initial begin
        tests = 0; fails = 0;
        wb_rst_i = 1'b1; en = 1'b0; r_wb = 1'b0; wbs_dat = '0;

        // ---------------- default instance ----------------
        sel = 1'b0;
        rows = 32; cols = 32; dw = 8; depth = 32; rdl = 44; wdl = 0; hold = 1;
        do_reset();

        do_write(32'h0660_00A5);
        do_read(0);
        chk("tp_read_a5", rd, 32'h0000_00A5);
        do_read(0);                       // empty: dropped

        do_rearm(32'h0000_0011 | ($urandom & 32'h3FF0_00FF));
        do_read(20);                      // aborted at acceptance+20
        chk("abort_keeps_entry", cnt, 1);
        do_read(0);

        // Fill to DEPTH, then an overflow write aimed at the first cell.
        first = $urandom;
        do_write(first);
        for (int i = 1; i < 32; i++) do_write($urandom);
        chk("fill_full", full, 1);
        do_write(first ^ 32'h0000_00FF);
        for (int i = 0; q.size() > 0; i++) do_read((i == 5) ? 7 : 0);
        chk("drain_empty", empty, 1);

        // Same cell written twice: both reads return the newer value.
        d = $urandom & 32'h3FF0_0000;
        do_write(d | 32'h0000_0033);
        do_write(d | 32'h0000_00C4);
        do_read(0);
        chk("overwrite_rd1", rd, 32'h0000_00C4);
        do_read(0);
        chk("overwrite_rd2", rd, 32'h0000_00C4);

        // Reset in the middle of a read.
        do_write($urandom | 32'h0000_0001);
        do_write($urandom);
        en = 1'b1; r_wb = 1'b1;
        tick();
        repeat (9) tick();
        chk("midrd_busy", busy, 1);
        chk("midrd_data_prev", rd, exp_rd);
        do_reset();

        // ---------------- latency / narrow-decode instance ----------------
        sel = 1'b1;
        rows = 8; cols = 4; dw = 12; depth = 4; rdl = 5; wdl = 3; hold = 4;
        do_reset();

        // Row field 26 aliases row 2, column field 23 aliases column 3.
        do_write({2'b01, 5'd26, 5'd23, 8'hFF, 12'hABC});
        do_read(0);
        chk("decode_rd", rd, 32'h0000_0ABC);
        do_write({2'b10, 5'd26, 5'd23, 8'h00, 12'h555});
        do_write({2'b00, 5'd2,  5'd3,  8'h00, 12'h123});
        do_read(0);
        chk("alias_rd", rd, 32'h0000_0123);
        do_read(0);

        for (int i = 0; i < 4; i++) do_write($urandom);
        chk("fill1_full", full, 1);
        do_write($urandom);
        while (q.size() > 0) do_read(0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_write($urandom);
            end else begin
                do_read(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
